key_event_fifo: RTL and testbench

- Sits between the PS/2 keyboard interface and the typing game controller.
- Turns the level-style rx_ascii / rx_released outputs into discrete key-press events, one per physical press.
- Buffers those events in a small show-ahead FIFO with a valid/ready handshake, so the controller can consume keystrokes at its own pace without losing fast typing bursts.
- Reports overflow and a saturating dropped-event count.

---
 rtl/typing_pkg.sv | 10 +
 rtl/key_event_fifo_detect.sv | 48 ++++
 rtl/key_event_fifo.sv | 163 ++++++++++++++++
 tb/tb_key_event_fifo.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/typing_pkg.sv
// Shared typing-game definitions: ASCII key type, "no key" code and the
// default key event FIFO depth. Also used by the game controller's string table.
package typing_pkg;

    typedef byte unsigned ascii_t;

    localparam ascii_t      KEY_NONE       = 8'h00;
    localparam int unsigned KEY_FIFO_DEPTH = 4;

endpackage : typing_pkg

// File: rtl/key_event_fifo_detect.sv
// key_press_detect: turns the level-style keyboard outputs into one-cycle
// press strobes, one per physical press.
//   clk, reset        : clock, async active-low reset
//   rx_ascii          : ASCII from keyboard interface (8'h00 = no printable key)
//   rx_released       : high while the last scan code was a break
//   press             : combinational strobe, a new press is present this cycle
//   press_ascii       : code that goes with press
module key_press_detect
    import typing_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_ascii,
    input  logic       rx_released,
    output logic       press,
    output logic [7:0] press_ascii
);

    logic       rel_prev_q;
    logic       rel_prev_d;
    logic [7:0] ascii_prev_q;
    logic [7:0] ascii_prev_d;

    // Previous-cycle snapshot, updated every cycle regardless of flush.
    always_comb begin
        rel_prev_d   = rx_released;
        ascii_prev_d = rx_ascii;
    end

    // rel_prev resets to 1 so a key held across reset release counts as new.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rel_prev_q   <= 1'b1;
            ascii_prev_q <= KEY_NONE;
        end else begin
            rel_prev_q   <= rel_prev_d;
            ascii_prev_q <= ascii_prev_d;
        end
    end

    // A press is a make code that follows a release or changes the key;
    // typematic repeats of the same code are ignored.
    assign press       = !rx_released
                       && (rel_prev_q || (rx_ascii != ascii_prev_q))
                       && (rx_ascii != KEY_NONE);
    assign press_ascii = rx_ascii;

endmodule : key_press_detect

// File: rtl/key_event_fifo.sv
// key_event_fifo: buffers key-press events between the PS/2 interface and the
// typing game controller in a show-ahead FIFO with valid/ready handshake.
//   clk, reset  : clock, async active-low reset
//   rx_ascii    : ASCII from keyboard interface
//   rx_released : break-code level from keyboard interface
//   flush       : synchronous clear of contents and status
//   ev_ready    : consumer takes the head event this cycle
//   ev_valid    : head event presented
//   ev_ascii    : head event code, 8'h00 when empty (combinational from head)
//   count       : occupancy 0..DEPTH
//   overflow    : sticky, an event was dropped since reset/flush
//   drop_count  : saturating number of dropped events
module key_event_fifo
    import typing_pkg::*;
#(
    parameter int unsigned DEPTH  = KEY_FIFO_DEPTH,
    parameter int unsigned CNT_W  = 3,
    parameter int unsigned DROP_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_ascii,
    input  logic              rx_released,
    input  logic              flush,
    input  logic              ev_ready,
    output logic              ev_valid,
    output logic [7:0]        ev_ascii,
    output logic [CNT_W-1:0]  count,
    output logic              overflow,
    output logic [DROP_W-1:0] drop_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_HOLD  = 1'b1
    } state_e;

    state_e              state_q;
    state_e              state_d;
    logic [PTR_W-1:0]    rd_ptr_q;
    logic [PTR_W-1:0]    rd_ptr_d;
    logic [PTR_W-1:0]    wr_ptr_q;
    logic [PTR_W-1:0]    wr_ptr_d;
    logic [CNT_W-1:0]    count_q;
    logic [CNT_W-1:0]    count_d;
    logic                overflow_q;
    logic                overflow_d;
    logic [DROP_W-1:0]   drop_count_q;
    logic [DROP_W-1:0]   drop_count_d;
    logic [7:0]          mem_q [DEPTH];

    logic                press;
    logic [7:0]          press_ascii;
    logic                full;
    logic                push;
    logic                pop;
    logic                accept;
    logic                drop;

    key_press_detect u_detect (
        .clk         (clk),
        .reset       (reset),
        .rx_ascii    (rx_ascii),
        .rx_released (rx_released),
        .press       (press),
        .press_ascii (press_ascii)
    );

    // Flush overrides both sides of the handshake.
    assign full   = (count_q == CNT_W'(DEPTH));
    assign push   = press && !flush;
    assign pop    = (state_q == ST_HOLD) && ev_ready && !flush;
    // A full FIFO still accepts when the head leaves in the same cycle.
    assign accept = push && (!full || pop);
    assign drop   = push && full && !pop;

    // Next-state: pointers, occupancy, status and controller FSM.
    always_comb begin
        state_d      = state_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        count_d      = count_q;
        overflow_d   = overflow_q;
        drop_count_d = drop_count_q;

        if (flush) begin
            state_d      = ST_EMPTY;
            rd_ptr_d     = '0;
            wr_ptr_d     = '0;
            count_d      = '0;
            overflow_d   = 1'b0;
            drop_count_d = '0;
        end else begin
            if (accept) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end

            case ({accept, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase

            if (drop) begin
                overflow_d = 1'b1;
                if (drop_count_q != '1) begin
                    drop_count_d = drop_count_q + DROP_W'(1);
                end
            end

            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (pop && !accept && (count_q == CNT_W'(1))) begin
                        state_d = ST_EMPTY;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_EMPTY;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            drop_count_q <= '0;
        end else begin
            state_q      <= state_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
            drop_count_q <= drop_count_d;
        end
    end

    // Storage has no reset; validity is tracked by count/state.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem_q[wr_ptr_q] <= press_ascii;
        end
    end

    assign ev_valid   = (state_q == ST_HOLD);
    assign ev_ascii   = (count_q == '0) ? KEY_NONE : mem_q[rd_ptr_q];
    assign count      = count_q;
    assign overflow   = overflow_q;
    assign drop_count = drop_count_q;

endmodule : key_event_fifo

// File: tb/tb_key_event_fifo.sv
// Scoreboard bench for key_event_fifo: stimulus queues expected event codes,
// a negedge monitor pops and compares on every handshake.
module tb_key_event_fifo;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rx_ascii;
    logic       rx_released;
    logic       flush;
    logic       ev_ready;
    logic       ev_valid;
    logic [7:0] ev_ascii;
    logic [2:0] count;
    logic       overflow;
    logic [7:0] drop_count;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q [$];

    key_event_fifo #(.DEPTH(4), .CNT_W(3), .DROP_W(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .rx_ascii    (rx_ascii),
        .rx_released (rx_released),
        .flush       (flush),
        .ev_ready    (ev_ready),
        .ev_valid    (ev_valid),
        .ev_ascii    (ev_ascii),
        .count       (count),
        .overflow    (overflow),
        .drop_count  (drop_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge.
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic key(input logic [7:0] a, input logic rel);
        rx_ascii    = a;
        rx_released = rel;
    endtask

    // Monitor: a handshake visible mid-cycle completes at the next rising edge.
    always @(negedge clk) begin
        logic [7:0] e;
        if (reset && ev_valid && ev_ready && !flush) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_underflow got %02h expected no event", ev_ascii);
            end else begin
                e = exp_q.pop_front();
                if (ev_ascii !== e) begin
                    errors++;
                    $display("FAIL sb_event got %02h expected %02h", ev_ascii, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0;
        key(8'h00, 1'b1);
        flush    = 1'b0;
        ev_ready = 1'b0;
        cyc(3);
        chk("rst_valid", int'(ev_valid), 0);
        chk("rst_count", int'(count), 0);
        chk("rst_ascii", int'(ev_ascii), 0);
        chk("rst_ovf", int'(overflow), 0);
        chk("rst_drop", int'(drop_count), 0);
        reset = 1'b1;
        cyc(2);

        // Held key gives exactly one event.
        key(8'h61, 1'b0);
        exp_q.push_back(8'h61);
        cyc(20);
        chk("hold_count", int'(count), 1);
        chk("hold_ascii", int'(ev_ascii), 8'h61);
        chk("hold_valid", int'(ev_valid), 1);
        ev_ready = 1'b1;
        cyc(1);
        ev_ready = 1'b0;
        chk("hold_pop_count", int'(count), 0);
        key(8'h61, 1'b1);
        cyc(1);

        // 'a' then 'b' without release, then drain.
        key(8'h61, 1'b0);
        exp_q.push_back(8'h61);
        cyc(1);
        key(8'h62, 1'b0);
        exp_q.push_back(8'h62);
        cyc(1);
        chk("ab_count", int'(count), 2);
        ev_ready = 1'b1;
        cyc(2);
        ev_ready = 1'b0;
        chk("ab_count0", int'(count), 0);
        chk("ab_ascii0", int'(ev_ascii), 0);
        chk("ab_valid0", int'(ev_valid), 0);
        key(8'h62, 1'b1);
        cyc(1);

        // Six presses into a 4-deep FIFO: last two dropped.
        for (int i = 0; i < 6; i++) begin
            key(8'h31 + 8'(i), 1'b0);
            if (i < 4) exp_q.push_back(8'h31 + 8'(i));
            cyc(1);
        end
        key(8'h36, 1'b1);
        cyc(1);
        chk("ovf_count", int'(count), 4);
        chk("ovf_flag", int'(overflow), 1);
        chk("ovf_drop", int'(drop_count), 2);

        // Full FIFO: press with simultaneous pop is accepted.
        key(8'h41, 1'b0);
        ev_ready = 1'b1;
        exp_q.push_back(8'h41);
        cyc(1);
        ev_ready = 1'b0;
        key(8'h41, 1'b1);
        chk("full_pp_count", int'(count), 4);
        chk("full_pp_drop", int'(drop_count), 2);
        ev_ready = 1'b1;
        cyc(4);
        ev_ready = 1'b0;
        chk("full_drain_count", int'(count), 0);
        chk("full_drain_valid", int'(ev_valid), 0);

        // Flush with a simultaneous press and ready.
        key(8'h51, 1'b0);
        cyc(1);
        key(8'h52, 1'b0);
        cyc(1);
        chk("fl_pre_count", int'(count), 2);
        key(8'h53, 1'b0);
        flush    = 1'b1;
        ev_ready = 1'b1;
        cyc(1);
        flush    = 1'b0;
        ev_ready = 1'b0;
        chk("fl_count", int'(count), 0);
        chk("fl_valid", int'(ev_valid), 0);
        chk("fl_ovf", int'(overflow), 0);
        chk("fl_drop", int'(drop_count), 0);
        cyc(3);
        chk("fl_held_count", int'(count), 0);
        key(8'h53, 1'b1);
        cyc(1);

        // Reset released while 'q' is held.
        reset = 1'b0;
        #1;
        chk("rq_rst_count", int'(count), 0);
        key(8'h71, 1'b0);
        cyc(2);
        reset = 1'b1;
        chk("rq_valid0", int'(ev_valid), 0);
        exp_q.push_back(8'h71);
        cyc(1);
        chk("rq_valid1", int'(ev_valid), 1);
        chk("rq_ascii", int'(ev_ascii), 8'h71);
        chk("rq_count", int'(count), 1);
        ev_ready = 1'b1;
        cyc(1);
        ev_ready = 1'b0;
        chk("rq_count0", int'(count), 0);
        key(8'h71, 1'b1);
        cyc(1);

        // Asynchronous reset in the middle of a burst.
        for (int i = 0; i < 3; i++) begin
            key(8'h61 + 8'(i), 1'b0);
            cyc(1);
        end
        key(8'h63, 1'b1);
        chk("ar_pre_count", int'(count), 3);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("ar_valid", int'(ev_valid), 0);
        chk("ar_count", int'(count), 0);
        chk("ar_ascii", int'(ev_ascii), 0);
        chk("ar_ovf", int'(overflow), 0);
        chk("ar_drop", int'(drop_count), 0);
        cyc(2);
        reset = 1'b1;
        cyc(2);
        chk("ar_post_count", int'(count), 0);

        chk("sb_left", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_key_event_fifo
